uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter ClksPerBit, default 16, giving i_clk cycles per serial bit (minimum 4).
REQ-002 SHALL have parameter FifoDepth, default 4, giving receive buffer entries (power of two).
REQ-003 SHALL have port i_clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rdena  input  1  active-low; drives data onto the data bus and pops one byte.
REQ-007 SHALL have port data  output  8  oldest buffered byte while rdena low, high-Z while rdena high.
REQ-008 SHALL have port rxready  output  1  active-high; buffer is non-empty (jump-logic status line).
REQ-009 SHALL have port rxerr  output  1  active-high sticky framing-or-overrun flag (jump-logic status line).

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer before any use; all timing below counts from the synchronized value.
REQ-011 SHALL implement the states IDLE, START, DATA, STOP with a bit-period counter and a 3-bit bit index.
REQ-012 IDLE: on a synchronized high-to-low transition SHALL enter START with the counter cleared.
REQ-013 START: after ClksPerBit/2 cycles SHALL sample rx; low -> DATA, high -> IDLE (glitch rejected, nothing stored).
REQ-014 DATA: SHALL sample one bit every ClksPerBit cycles at mid-bit into a shift register, LSB first, and enter STOP after bit 7.
REQ-015 STOP: after ClksPerBit cycles SHALL sample rx; high -> push the byte; low -> discard the byte and set rxerr; both -> IDLE.
REQ-016 A pushed byte SHALL be visible on data and rxready SHALL be high from the cycle after the stop-bit sample.
REQ-017 A pop SHALL occur at each rising i_clk edge at which rdena is low and the buffer is non-empty.
REQ-018 A pop SHALL also clear rxerr, unless a new error is flagged on the same edge, in which case rxerr SHALL stay set.
REQ-019 rdena low with the buffer empty SHALL drive data=8'h00, change no pointer and leave rxerr unchanged.
REQ-020 A push with the buffer full SHALL drop the new byte, keep stored bytes and set rxerr.
REQ-021 Push and pop on the same edge SHALL both take effect, including when full (no overrun); occupancy is unchanged.
REQ-022 Read and write pointers SHALL wrap modulo FifoDepth; occupancy SHALL be tracked so full and empty are distinct.
REQ-023 Line activity during STOP-to-IDLE SHALL be ignored until IDLE is entered; back-to-back frames with one stop bit SHALL be received.

Reset
REQ-024 reset low SHALL immediately force IDLE, clear counter, bit index, shift register, pointers and occupancy, and set rxready=0 and rxerr=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; after release the receiver SHALL wait for a fresh falling edge.
REQ-026 The synchronizer SHALL reset to 1 (idle), so that release of reset with rx high causes no false start.

Structure
REQ-027 State encodings, the 8N1 frame length and the ClksPerBit default SHALL live in the shared UART definitions header, also used by the transmitter.
REQ-028 The buffer SHALL be a sub-module uart_rx_fifo (push/pop/full/empty), instantiated once; the bit FSM stays in uart_rx.

Verification (ClksPerBit=16, FifoDepth=4)
REQ-029 Send 0x3F with a valid stop -> rxready rises 1 cycle after the stop sample; rdena low for 1 cycle -> data=0x3F, then rxready=0.
REQ-030 Drive rx low for 4 cycles, then high -> no byte, rxready=0, rxerr=0, FSM back in IDLE.
REQ-031 Send 0xA5 with a low stop bit -> rxerr=1, rxready=0; a later valid 0x5A then a pop -> data=0x5A, rxerr=0.
REQ-032 Send 0x01..0x05 with no reads -> rxerr=1; four pops return 0x01,0x02,0x03,0x04, then rxready=0.
REQ-033 Pop on the same edge that 0x05 is pushed into a full buffer -> no overrun; the remaining pops return 0x02,0x03,0x04,0x05.
REQ-034 Assert reset during bit 4 of 0xC3, then send 0x81 -> only 0x81 is received, with no spurious byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// frame geometry, default bit period and the bit-level FSM state encoding.
package uart_pkg;

    localparam int CLKS_PER_BIT = 16;
    localparam int DATA_BITS    = 8;
    localparam int FRAME_BITS   = 1 + DATA_BITS + 1;  // 8N1: start + data + stop

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: power-of-two depth, wrapping pointers plus an explicit
// occupancy count so full and empty are distinct; push and pop may coincide.
module uart_rx_fifo #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [Width-1:0] i_wdata,
    output logic [Width-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CntW'(Depth));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop on the same edge frees the slot, so a push into a full buffer still lands.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; empty/full come from the count, so contents never matter.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, start/data/stop bit FSM sampling at mid-bit,
// and a small byte buffer read through an active-low tri-state data port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClksPerBit = CLKS_PER_BIT,
    parameter int FifoDepth  = 4
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rdena,
    output logic [7:0] data,
    output logic       rxready,
    output logic       rxerr
);

    localparam int CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] HALF_M1 = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FULL_M1 = CntW'(ClksPerBit - 1);

    uart_state_e r_state;
    uart_state_e w_next;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic [CntW-1:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_err;

    logic w_fall, w_half_done, w_bit_done;
    logic w_cnt_clear, w_shift_en, w_push, w_frame_err;
    logic w_pop, w_overrun;
    logic w_full, w_empty;
    logic [7:0] w_rdata;

    // Synchronizer and edge history reset to idle so reset release never looks like a start.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall      = r_rx_prev & ~r_rx_sync;
    assign w_half_done = (r_cnt == HALF_M1);
    assign w_bit_done  = (r_cnt == FULL_M1);

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_fall) w_next = ST_START;
            ST_START: if (w_half_done) w_next = r_rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_bit_done && r_bit_idx == 3'd7) w_next = ST_STOP;
            ST_STOP:  if (w_bit_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_clear = 1'b0;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            ST_IDLE:  w_cnt_clear = 1'b1;
            ST_START: w_cnt_clear = w_half_done;
            ST_DATA: begin
                w_cnt_clear = w_bit_done;
                w_shift_en  = w_bit_done;
            end
            ST_STOP: begin
                w_cnt_clear = w_bit_done;
                w_push      = w_bit_done & r_rx_sync;
                w_frame_err = w_bit_done & ~r_rx_sync;
            end
            default: w_cnt_clear = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt <= w_cnt_clear ? '0 : r_cnt + CntW'(1);
            if (w_shift_en) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    assign w_pop     = ~rdena & ~w_empty;
    // Full implies non-empty, so a low rdena always frees a slot on the same edge.
    assign w_overrun = w_push & w_full & rdena;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset)                       r_err <= 1'b0;
        else if (w_frame_err | w_overrun) r_err <= 1'b1;
        else if (w_pop)                   r_err <= 1'b0;
    end

    uart_rx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (r_shift),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign data    = rdena ? 8'hzz : (w_empty ? 8'h00 : w_rdata);
    assign rxready = ~w_empty;
    assign rxerr   = r_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: reset, directed frame/buffer corner cases,
// a vector table and randomized frames checked against a byte-queue model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       i_clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       rdena = 1'b1;
    wire  [7:0] data;
    logic       rxready;
    logic       rxerr;

    uart_rx #(.ClksPerBit(CPB), .FifoDepth(DEPTH)) dut (
        .i_clk   (i_clk),
        .reset   (reset),
        .rx      (rx),
        .rdena   (rdena),
        .data    (data),
        .rxready (rxready),
        .rxerr   (rxerr)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: received bytes in arrival order plus the sticky error flag.
    logic [7:0] model_q[$];
    bit         model_err = 1'b0;

    typedef struct {
        logic [7:0] byte_v;
        bit         stop_ok;
        bit         do_pop;
        logic [7:0] exp_data;
        bit         exp_ready;
        bit         exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_head();
        return (model_q.size() != 0) ? model_q[0] : 8'h00;
    endfunction

    // Called at a negedge; holds rdena low across exactly one rising edge.
    task automatic pop_byte(input string name, input logic [7:0] exp);
        logic [7:0] dropped;
        rdena = 1'b0;
        #1;
        check(name, {24'h0, data}, {24'h0, exp});
        @(negedge i_clk);
        rdena = 1'b1;
        if (model_q.size() != 0) begin
            dropped   = model_q.pop_front();
            model_err = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok)                         model_err = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else                             model_err = 1'b1;
    endtask

    // Drives one 8N1 frame starting at the current negedge. pop_at_stop reads
    // on the edge the stop bit is sampled; reset_bit >= 0 holds reset low from
    // mid-way through that data bit until the frame has ended.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit pop_at_stop, input int reset_bit);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == 9 && pop_at_stop) begin
                repeat (10) @(negedge i_clk);
                pop_byte("pop_on_push_edge", model_head());
                repeat (5) @(negedge i_clk);
            end else if (reset_bit >= 0 && i == reset_bit + 1) begin
                repeat (CPB / 2) @(negedge i_clk);
                reset = 1'b0;
                repeat (CPB / 2) @(negedge i_clk);
            end else begin
                repeat (CPB) @(negedge i_clk);
            end
        end
        rx = 1'b1;
        if (reset_bit >= 0) begin
            repeat (4) @(negedge i_clk);
            reset = 1'b1;
            model_q.delete();
            model_err = 1'b0;
        end else begin
            model_frame(b, stop_ok);
        end
        if (!stop_ok) repeat (4) @(negedge i_clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h3F, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[3] = '{8'hC3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        // Reset state
        repeat (4) @(negedge i_clk);
        check("reset_rxready", {31'h0, rxready}, 32'h0);
        check("reset_rxerr", {31'h0, rxerr}, 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge i_clk);
        check("release_rxready", {31'h0, rxready}, 32'h0);
        pop_byte("empty_read_data", 8'h00);
        check("empty_read_rxerr", {31'h0, rxerr}, 32'h0);
        check("empty_read_rxready", {31'h0, rxready}, 32'h0);

        // Start edge at N0 is synchronized by P2, seen as an edge at P3,
        // mid-start at P11, stop sampled at P11 + 9*16 = P155.
        fork
            send_frame(8'h3F, 1'b1, 1'b0, -1);
            begin
                repeat (154) @(negedge i_clk);
                check("ready_before_stop_sample", {31'h0, rxready}, 32'h0);
                @(negedge i_clk);
                check("ready_after_stop_sample", {31'h0, rxready}, 32'h1);
            end
        join
        pop_byte("first_byte_data", 8'h3F);
        check("first_byte_ready_after_pop", {31'h0, rxready}, 32'h0);

        // Short low glitch is rejected at the mid-start sample
        rx = 1'b0;
        repeat (4) @(negedge i_clk);
        rx = 1'b1;
        repeat (20) @(negedge i_clk);
        check("glitch_rxready", {31'h0, rxready}, 32'h0);
        check("glitch_rxerr", {31'h0, rxerr}, 32'h0);
        check("glitch_state_idle", {30'h0, dut.r_state}, {30'h0, ST_IDLE});

        // Vector table: frame, optional pop, then status
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].byte_v, vecs[i].stop_ok, 1'b0, -1);
            if (vecs[i].do_pop) pop_byte($sformatf("vec%0d_data", i), vecs[i].exp_data);
            check($sformatf("vec%0d_rxready", i), {31'h0, rxready}, {31'h0, vecs[i].exp_ready});
            check($sformatf("vec%0d_rxerr", i), {31'h0, rxerr}, {31'h0, vecs[i].exp_err});
        end

        // Overrun: fifth byte dropped, first four kept
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, -1);
        check("overrun_rxerr", {31'h0, rxerr}, 32'h1);
        check("overrun_rxready", {31'h0, rxready}, 32'h1);
        for (int b = 1; b <= 4; b++) pop_byte($sformatf("overrun_pop%0d", b), 8'(b));
        check("overrun_drained", {31'h0, rxready}, 32'h0);
        check("overrun_err_cleared", {31'h0, rxerr}, 32'h0);

        // Pop on the same edge as a push into a full buffer
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b0, -1);
        send_frame(8'h05, 1'b1, 1'b1, -1);
        check("simul_no_overrun", {31'h0, rxerr}, 32'h0);
        check("simul_still_full", {31'h0, rxready}, 32'h1);
        for (int b = 2; b <= 5; b++) pop_byte($sformatf("simul_pop%0d", b), 8'(b));
        check("simul_drained", {31'h0, rxready}, 32'h0);

        // Reset mid-frame discards the partial byte and the sticky error
        send_frame(8'h11, 1'b0, 1'b0, -1);
        check("pre_reset_rxerr", {31'h0, rxerr}, 32'h1);
        send_frame(8'hC3, 1'b1, 1'b0, 4);
        repeat (40) @(negedge i_clk);
        check("midreset_rxready", {31'h0, rxready}, 32'h0);
        check("midreset_rxerr", {31'h0, rxerr}, 32'h0);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        check("post_reset_ready", {31'h0, rxready}, 32'h1);
        pop_byte("post_reset_data", 8'h81);
        check("post_reset_single", {31'h0, rxready}, 32'h0);

        // Randomized frames, stop errors, gaps (including back-to-back) and reads
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 1'b0, -1);
            check("rand_rxready", {31'h0, rxready}, {31'h0, (model_q.size() != 0)});
            check("rand_rxerr", {31'h0, rxerr}, {31'h0, model_err});
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) pop_byte("rand_pop", model_head());
            end
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end
        while (model_q.size() != 0) pop_byte("final_drain", model_head());
        check("final_empty", {31'h0, rxready}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
